// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: shares one synchronous data RAM between the MEM
// stage and a debug port, with bounded debug starvation and a capped bus lock.
module dmem_arbiter #(
  parameter int MAX_WAIT = 4,
  parameter int LOCK_MAX = 16
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_rvalid,
  output logic        pipe_stall,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic        dbg_lock,
  input  logic [31:0] dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic        dbg_ack,
  output logic [31:0] dbg_rdata,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  output logic        ram_we,
  input  logic [31:0] ram_rdata
);

  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam int LW = $clog2(LOCK_MAX + 1);
  localparam logic [WW-1:0] WAIT_SAT = WW'(MAX_WAIT);
  localparam logic [LW-1:0] LOCK_SAT = LW'(LOCK_MAX);

  typedef enum logic [1:0] {S_IDLE, S_CPU, S_DBG, S_LOCK} state_t;

  state_t        state_q, state_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [LW-1:0] lock_q, lock_d;
  logic          relock_q, relock_d;
  logic          rvalid_q, rvalid_d;
  logic          ack_q, ack_d;
  logic          dbg_rd_q, dbg_rd_d;
  logic          cpu_gnt, dbg_gnt, forced_exit;

  // Grant is purely combinational; reset suppresses every grant.
  always_comb begin
    cpu_gnt = 1'b0;
    dbg_gnt = 1'b0;
    if (!cpu_rst) begin
      if (state_q == S_LOCK) begin
        dbg_gnt = dbg_req;
      end else begin
        dbg_gnt = dbg_req && (!mem_req || (wait_q == WAIT_SAT));
        cpu_gnt = mem_req && !dbg_gnt;
      end
    end
  end

  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (cpu_gnt) begin
      ram_we    = mem_we;
      ram_addr  = mem_addr;
      ram_wdata = mem_wdata;
    end else if (dbg_gnt) begin
      ram_we    = dbg_we;
      ram_addr  = dbg_addr;
      ram_wdata = dbg_wdata;
    end
  end

  // Responses issued before a reset are dropped while reset is held.
  assign pipe_stall = mem_req && !cpu_gnt && !cpu_rst;
  assign mem_rvalid = rvalid_q && !cpu_rst;
  assign mem_rdata  = mem_rvalid ? ram_rdata : '0;
  assign dbg_ack    = ack_q && !cpu_rst;
  assign dbg_rdata  = (dbg_ack && dbg_rd_q) ? ram_rdata : '0;

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    lock_d      = lock_q;
    relock_d    = relock_q;
    forced_exit = 1'b0;
    rvalid_d    = cpu_gnt && !mem_we;
    ack_d       = dbg_gnt;
    dbg_rd_d    = dbg_gnt && !dbg_we;

    case (state_q)
      S_LOCK: begin
        if (!dbg_lock || (lock_q == LOCK_SAT)) begin
          state_d     = S_IDLE;
          lock_d      = '0;
          forced_exit = dbg_lock;
        end else begin
          lock_d = lock_q + LW'(1);
        end
      end
      default: begin
        lock_d = '0;
        if (dbg_gnt) begin
          if (dbg_lock && !relock_q) begin
            state_d = S_LOCK;
            lock_d  = LW'(1);
          end else begin
            state_d = S_DBG;
          end
        end else if (cpu_gnt) begin
          state_d = S_CPU;
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase

    // A forced exit hands the next cycle back to the CPU by restarting the wait.
    if (forced_exit || !dbg_req || dbg_gnt) begin
      wait_d = '0;
    end else if (wait_q != WAIT_SAT) begin
      wait_d = wait_q + WW'(1);
    end

    if (forced_exit) begin
      relock_d = 1'b1;
    end else if (!dbg_lock) begin
      relock_d = 1'b0;
    end
  end

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      state_q  <= S_IDLE;
      wait_q   <= '0;
      lock_q   <= '0;
      relock_q <= 1'b0;
      rvalid_q <= 1'b0;
      ack_q    <= 1'b0;
      dbg_rd_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      lock_q   <= lock_d;
      relock_q <= relock_d;
      rvalid_q <= rvalid_d;
      ack_q    <= ack_d;
      dbg_rd_q <= dbg_rd_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios followed by random
// traffic, all compared against a cycle-level reference model of the arbitration rules.
module tb_dmem_arbiter;

   localparam int MAX_WAIT = 4;
   localparam int LOCK_MAX = 16;

   logic        clk;
   logic        rst;
   logic        memReq, memWe, dbgReq, dbgWe, dbgLock;
   logic [31:0] memAddr, memWdata, dbgAddr, dbgWdata;
   logic [31:0] memRdata, dbgRdata, ramAddr, ramWdata, ramRdata;
   logic        memRvalid, pipeStall, dbgAck, ramWe;

   logic [31:0] ram [0:1023];
   logic [31:0] refMem [0:1023];

   int checks = 0;
   int errors = 0;
   int stallCount;

   // Reference model state, kept as plain integers and flags
   bit          mLocked, mRelock, mPendRv, mPendAck, mPendDbgRd;
   int          mLockCnt, mWait;
   logic [31:0] mPendRd, mPendDbgData;
   bit          gCpu, gDbg;
   logic [31:0] expRamAddr, expRamWdata, expRdata, expDbgRdata;
   bit          expRamWe, expRv, expAck, expStall;

   dmem_arbiter #(.MAX_WAIT(MAX_WAIT), .LOCK_MAX(LOCK_MAX)) dut (
      .cpu_clk(clk), .cpu_rst(rst),
      .mem_req(memReq), .mem_we(memWe), .mem_addr(memAddr), .mem_wdata(memWdata),
      .mem_rdata(memRdata), .mem_rvalid(memRvalid), .pipe_stall(pipeStall),
      .dbg_req(dbgReq), .dbg_we(dbgWe), .dbg_lock(dbgLock),
      .dbg_addr(dbgAddr), .dbg_wdata(dbgWdata),
      .dbg_ack(dbgAck), .dbg_rdata(dbgRdata),
      .ram_addr(ramAddr), .ram_wdata(ramWdata), .ram_we(ramWe), .ram_rdata(ramRdata)
   );

   // Free-running clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Synchronous data RAM behind the arbiter: read data appears one cycle after the address
   always @(posedge clk) begin
      if (ramWe) ram[ramAddr[9:0]] <= ramWdata;
      ramRdata <= ram[ramAddr[9:0]];
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Expected combinational outputs for the current cycle from the model state
   task automatic modelOutputs();
      gCpu = 0; gDbg = 0;
      expRv = 0; expRdata = 0; expAck = 0; expDbgRdata = 0;
      if (!rst) begin
         expRv = mPendRv;
         expRdata = mPendRv ? mPendRd : 32'h0;
         expAck = mPendAck;
         expDbgRdata = (mPendAck && mPendDbgRd) ? mPendDbgData : 32'h0;
         if (mLocked) begin
            gDbg = dbgReq;
         end else begin
            gDbg = dbgReq && (!memReq || mWait == MAX_WAIT);
            gCpu = memReq && !gDbg;
         end
      end
      expStall = !rst && memReq && !gCpu;
      expRamWe = 0; expRamAddr = 0; expRamWdata = 0;
      if (gCpu) begin
         expRamWe = memWe; expRamAddr = memAddr; expRamWdata = memWdata;
      end else if (gDbg) begin
         expRamWe = dbgWe; expRamAddr = dbgAddr; expRamWdata = dbgWdata;
      end
   endtask

   // Advance the model by one clock edge using this cycle's inputs and grants
   task automatic modelUpdate();
      bit forced;
      if (rst) begin
         mLocked = 0; mRelock = 0; mLockCnt = 0; mWait = 0;
         mPendRv = 0; mPendAck = 0; mPendDbgRd = 0;
      end else begin
         forced = mLocked && dbgLock && mLockCnt == LOCK_MAX;
         mPendRv = gCpu && !memWe;
         mPendRd = refMem[memAddr[9:0]];
         mPendAck = gDbg;
         mPendDbgRd = gDbg && !dbgWe;
         mPendDbgData = refMem[dbgAddr[9:0]];
         if (gCpu && memWe) refMem[memAddr[9:0]] = memWdata;
         if (gDbg && dbgWe) refMem[dbgAddr[9:0]] = dbgWdata;
         if (forced || !dbgReq || gDbg) mWait = 0;
         else mWait = (mWait + 1 > MAX_WAIT) ? MAX_WAIT : mWait + 1;
         if (mLocked) begin
            if (!dbgLock || mLockCnt == LOCK_MAX) begin
               mLocked = 0; mLockCnt = 0;
            end else begin
               mLockCnt++;
            end
         end else if (gDbg && dbgLock && !mRelock) begin
            mLocked = 1; mLockCnt = 1;
         end
         if (forced) mRelock = 1;
         else if (!dbgLock) mRelock = 0;
      end
   endtask

   // Drive one cycle of inputs away from the active edge, then compare every output to the model
   task automatic applyStimulus(input bit iRst, input bit iMemReq, input bit iMemWe,
                                input logic [31:0] iMemAddr, input logic [31:0] iMemWdata,
                                input bit iDbgReq, input bit iDbgWe, input bit iDbgLock,
                                input logic [31:0] iDbgAddr, input logic [31:0] iDbgWdata);
      @(negedge clk);
      rst = iRst; memReq = iMemReq; memWe = iMemWe; memAddr = iMemAddr; memWdata = iMemWdata;
      dbgReq = iDbgReq; dbgWe = iDbgWe; dbgLock = iDbgLock; dbgAddr = iDbgAddr; dbgWdata = iDbgWdata;
      #1;
      modelOutputs();
      checkOutput("pipe_stall", {31'b0, pipeStall}, {31'b0, expStall});
      checkOutput("ram_we", {31'b0, ramWe}, {31'b0, expRamWe});
      checkOutput("ram_addr", ramAddr, expRamAddr);
      checkOutput("ram_wdata", ramWdata, expRamWdata);
      checkOutput("mem_rvalid", {31'b0, memRvalid}, {31'b0, expRv});
      checkOutput("mem_rdata", memRdata, expRdata);
      checkOutput("dbg_ack", {31'b0, dbgAck}, {31'b0, expAck});
      checkOutput("dbg_rdata", dbgRdata, expDbgRdata);
   endtask

   task automatic clockEdge();
      @(posedge clk);
      modelUpdate();
   endtask

   initial begin
      bit rLock;
      rst = 1; memReq = 0; memWe = 0; memAddr = 0; memWdata = 0;
      dbgReq = 0; dbgWe = 0; dbgLock = 0; dbgAddr = 0; dbgWdata = 0;
      mLocked = 0; mRelock = 0; mLockCnt = 0; mWait = 0;
      mPendRv = 0; mPendAck = 0; mPendDbgRd = 0; mPendRd = 0; mPendDbgData = 0;
      for (int i = 0; i < 1024; i++) begin
         ram[i] = 32'hA500_0000 + i * 32'h0001_0013;
         refMem[i] = 32'hA500_0000 + i * 32'h0001_0013;
      end
      ram[256] = 32'hDEADBEEF;
      refMem[256] = 32'hDEADBEEF;

      // Reset
      applyStimulus(1, 1, 0, 32'h10, 0, 1, 0, 0, 32'h20, 0); clockEdge();
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); clockEdge();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); clockEdge();

      // Lone CPU read of 0x100
      $display("[TB] CPU read 0x100");
      applyStimulus(0, 1, 0, 32'h100, 0, 0, 0, 0, 0, 0);
      checkOutput("cpu_rd_addr", ramAddr, 32'h100);
      checkOutput("cpu_rd_nostall", {31'b0, pipeStall}, 32'h0);
      clockEdge();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("cpu_rd_rvalid", {31'b0, memRvalid}, 32'h1);
      checkOutput("cpu_rd_data", memRdata, 32'hDEADBEEF);
      clockEdge();

      // Debug write with an idle pipeline
      $display("[TB] debug write 0x55 to 0x200");
      applyStimulus(0, 0, 0, 0, 0, 1, 1, 0, 32'h200, 32'h55);
      checkOutput("dbg_wr_we", {31'b0, ramWe}, 32'h1);
      checkOutput("dbg_wr_addr", ramAddr, 32'h200);
      checkOutput("dbg_wr_data", ramWdata, 32'h55);
      clockEdge();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("dbg_wr_ack", {31'b0, dbgAck}, 32'h1);
      clockEdge();

      // Contention: CPU keeps the bus for MAX_WAIT cycles, then debug is forced through
      $display("[TB] contention");
      for (int c = 1; c <= MAX_WAIT + 1; c++) begin
         applyStimulus(0, 1, 0, 32'h40 + c, 0, 1, 0, 0, 32'h300, 0);
         checkOutput("contend_stall", {31'b0, pipeStall}, (c == MAX_WAIT + 1) ? 32'h1 : 32'h0);
         clockEdge();
      end
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("contend_ack", {31'b0, dbgAck}, 32'h1);
      checkOutput("contend_rdata", dbgRdata, refMem[10'h300]);
      clockEdge();

      // Long lock: capped at LOCK_MAX cycles, then the CPU gets the bus with no relock
      $display("[TB] lock cap");
      applyStimulus(0, 0, 0, 0, 0, 1, 0, 1, 32'h8, 0); clockEdge();
      stallCount = 0;
      for (int c = 0; c < 20; c++) begin
         applyStimulus(0, 1, 0, 32'h80 + c, 0, 1, 0, 1, 32'h8 + c, 0);
         if (pipeStall) stallCount++;
         clockEdge();
      end
      checkOutput("lock_stall_cycles", stallCount, LOCK_MAX);
      applyStimulus(0, 0, 0, 0, 0, 1, 0, 1, 32'h9, 0); clockEdge();
      applyStimulus(0, 1, 0, 32'h90, 0, 1, 0, 1, 32'h9, 0);
      checkOutput("no_relock_cpu", {31'b0, pipeStall}, 32'h0);
      clockEdge();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); clockEdge();
      applyStimulus(0, 0, 0, 0, 0, 1, 0, 1, 32'hA, 0); clockEdge();
      applyStimulus(0, 1, 0, 32'h91, 0, 1, 0, 1, 32'hB, 0);
      checkOutput("relock_stall", {31'b0, pipeStall}, 32'h1);
      clockEdge();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); clockEdge();

      // Reset in the third lock cycle with a debug read outstanding
      $display("[TB] reset mid-lock");
      applyStimulus(0, 0, 0, 0, 0, 1, 0, 1, 32'h30, 0); clockEdge();
      applyStimulus(0, 0, 0, 0, 0, 1, 0, 1, 32'h31, 0); clockEdge();
      applyStimulus(0, 0, 0, 0, 0, 1, 0, 1, 32'h32, 0); clockEdge();
      applyStimulus(1, 1, 0, 32'h33, 0, 1, 0, 1, 32'h33, 0);
      checkOutput("rst_ram_we", {31'b0, ramWe}, 32'h0);
      checkOutput("rst_stall", {31'b0, pipeStall}, 32'h0);
      checkOutput("rst_ack", {31'b0, dbgAck}, 32'h0);
      clockEdge();
      applyStimulus(0, 1, 0, 32'h34, 0, 0, 0, 0, 0, 0);
      checkOutput("post_rst_ack", {31'b0, dbgAck}, 32'h0);
      checkOutput("post_rst_rvalid", {31'b0, memRvalid}, 32'h0);
      checkOutput("post_rst_stall", {31'b0, pipeStall}, 32'h0);
      clockEdge();

      // Random traffic against the model
      $display("[TB] random traffic");
      rLock = 0;
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 23) == 0) rLock = !rLock;
         applyStimulus($urandom_range(0, 79) == 0,
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       32'($urandom_range(0, 1023)), $urandom,
                       $urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)), rLock,
                       32'($urandom_range(0, 1023)), $urandom);
         clockEdge();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
